// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used by the fetch line buffer.
package lc3b_types;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;
endpackage

// File: rtl/ifetch_line_buffer_line_word_select.sv
// Pick one 16-bit instruction word out of an eight-word line.
module line_word_select
  import lc3b_types::*;
(
  input  lc3b_line   line,
  input  logic [2:0] offset,
  output lc3b_word   word
);
  lc3b_word words [8];

  // Split the line into its words; word k sits at bits [16k+15:16k].
  for (genvar k = 0; k < 8; k++) begin : g_word
    assign words[k] = line[16*k +: 16];
  end

  assign word = words[offset];
endmodule

// File: rtl/ifetch_line_buffer.sv
// Single-line instruction fetch buffer: zero-wait hits, one line fill on miss.
module ifetch_line_buffer
  import lc3b_types::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      read_a,
  input  lc3b_word  address_a,
  input  logic      flush,
  output logic      resp_a,
  output lc3b_word  rdata_a,
  output logic      pmem_read,
  output lc3b_word  pmem_address,
  input  logic      pmem_resp,
  input  lc3b_line  pmem_rdata
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]  state;
  logic        valid;
  logic        discard;
  logic [11:0] tag;
  logic [11:0] fill_tag;
  lc3b_line    data;
  lc3b_word    sel_word;
  logic        hit;

  line_word_select u_sel (
    .line   (data),
    .offset (address_a[3:1]),
    .word   (sel_word)
  );

  // Hit is purely combinational so a buffered word returns with no wait state;
  // a flush in the same cycle wins over the hit.
  always_comb begin
    hit          = (state == IDLE) && read_a && valid &&
                   (tag == address_a[15:4]) && !flush;
    resp_a       = hit;
    rdata_a      = hit ? sel_word : 16'h0000;
    pmem_read    = (state == FILL);
    pmem_address = (state == FILL) ? {fill_tag, 4'b0000} : 16'h0000;
  end

  // Control state: FSM, valid and discard tracking; reset abandons any fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      valid    <= 1'b0;
      discard  <= 1'b0;
      fill_tag <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) valid <= 1'b0;
          if (read_a && !hit) begin
            state    <= FILL;
            fill_tag <= address_a[15:4];
          end
        end
        default: begin
          // A flush at any point in the fill poisons the incoming line.
          if (flush) discard <= 1'b1;
          if (pmem_resp) begin
            valid   <= !(discard || flush);
            discard <= 1'b0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

  // Line storage: data and tag carry no reset, only written at fill completion.
  always_ff @(posedge clk) begin
    if (state == FILL && pmem_resp) begin
      data <= pmem_rdata;
      tag  <= fill_tag;
    end
  end
endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Directed self-checking bench for ifetch_line_buffer.
module tb_ifetch_line_buffer;
  import lc3b_types::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      read_a;
  lc3b_word  address_a;
  logic      flush;
  logic      resp_a;
  lc3b_word  rdata_a;
  logic      pmem_read;
  lc3b_word  pmem_address;
  logic      pmem_resp;
  lc3b_line  pmem_rdata;

  int n_run  = 0;
  int n_fail = 0;

  ifetch_line_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .read_a       (read_a),
    .address_a    (address_a),
    .flush        (flush),
    .resp_a       (resp_a),
    .rdata_a      (rdata_a),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Line whose word k is base+k.
  function automatic lc3b_line mk_line(input lc3b_word base);
    lc3b_line l;
    for (int k = 0; k < 8; k++) l[16*k +: 16] = base + 16'(k);
    return l;
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Sitting in FILL: wait (n-1) idle cycles, then pulse pmem_resp with line.
  task automatic fill(input int n, input lc3b_line line, input string tag);
    for (int i = 0; i < n - 1; i++) begin
      #1 chk({tag, "_hold_rd"}, 32'(pmem_read), 32'd1);
      cyc;
    end
    pmem_resp = 1'b1;
    pmem_rdata = line;
    #1 chk({tag, "_fill_resp0"}, 32'(resp_a), 32'd0);
    cyc;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
  endtask

  initial begin
    reset = 1'b1; read_a = 1'b0; address_a = '0; flush = 1'b0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    #3;
    chk("rst_resp", 32'(resp_a), 32'd0);
    chk("rst_rdata", 32'(rdata_a), 32'd0);
    chk("rst_pread", 32'(pmem_read), 32'd0);
    chk("rst_paddr", 32'(pmem_address), 32'd0);
    cyc; cyc;
    reset = 1'b0;

    // Miss at 3004, fill after 3 cycles, hit returns word2.
    read_a = 1'b1; address_a = 16'h3004;
    #1 chk("miss_resp", 32'(resp_a), 32'd0);
    chk("miss_pread_idle", 32'(pmem_read), 32'd0);
    cyc;
    chk("fill_pread", 32'(pmem_read), 32'd1);
    chk("fill_paddr", 32'(pmem_address), 32'h3000);
    fill(3, mk_line(16'h1232), "f3000");
    #1 chk("hit_resp", 32'(resp_a), 32'd1);
    chk("hit_rdata", 32'(rdata_a), 32'h1234);

    // Eight back-to-back hits across the line.
    for (int i = 0; i < 8; i++) begin
      address_a = 16'h3000 + 16'(2*i);
      #1 chk($sformatf("seq_resp%0d", i), 32'(resp_a), 32'd1);
      chk($sformatf("seq_rdata%0d", i), 32'(rdata_a), 32'(16'h1232 + 16'(i)));
      chk($sformatf("seq_pread%0d", i), 32'(pmem_read), 32'd0);
      cyc;
    end

    // Crossing into the next line misses.
    address_a = 16'h3010;
    #1 chk("next_resp", 32'(resp_a), 32'd0);
    chk("next_rdata0", 32'(rdata_a), 32'd0);
    cyc;
    chk("next_paddr", 32'(pmem_address), 32'h3010);
    fill(1, mk_line(16'h5000), "f3010");
    address_a = 16'h301C;
    #1 chk("next_hit", 32'(rdata_a), 32'h5006);
    cyc;

    // Reload 3000, then flush on a would-be hit.
    address_a = 16'h3002;
    cyc;
    fill(2, mk_line(16'h1232), "r3000");
    #1 chk("reload_hit", 32'(rdata_a), 32'h1233);
    cyc;
    flush = 1'b1;
    #1 chk("flush_hit_resp", 32'(resp_a), 32'd0);
    cyc;
    flush = 1'b0;
    chk("flush_fill_pread", 32'(pmem_read), 32'd1);
    chk("flush_fill_paddr", 32'(pmem_address), 32'h3000);
    fill(1, mk_line(16'h1232), "ff3000");
    #1 chk("flush_refill_hit", 32'(resp_a), 32'd1);

    // Invalidate in IDLE, then address changes mid-fill.
    read_a = 1'b0; flush = 1'b1;
    cyc;
    flush = 1'b0; read_a = 1'b1; address_a = 16'h3000;
    #1 chk("inv_miss", 32'(resp_a), 32'd0);
    cyc;
    address_a = 16'h4000;
    #1 chk("chg_paddr_stable", 32'(pmem_address), 32'h3000);
    fill(2, mk_line(16'h1232), "chg");
    #1 chk("chg_miss", 32'(resp_a), 32'd0);
    cyc;
    chk("chg_paddr", 32'(pmem_address), 32'h4000);
    fill(1, mk_line(16'h4000), "f4000");
    address_a = 16'h4006;
    #1 chk("chg_hit", 32'(rdata_a), 32'h4003);

    // Flush mid-fill leaves the line invalid.
    address_a = 16'h3000;
    cyc;
    flush = 1'b1;
    #1 cyc;
    flush = 1'b0;
    fill(2, mk_line(16'h1232), "disc");
    #1 chk("disc_remiss", 32'(resp_a), 32'd0);
    cyc;
    chk("disc_paddr", 32'(pmem_address), 32'h3000);
    // Flush coincident with pmem_resp also discards.
    flush = 1'b1;
    fill(1, mk_line(16'h1232), "disc2");
    flush = 1'b0;
    #1 chk("disc2_remiss", 32'(resp_a), 32'd0);
    cyc;
    fill(1, mk_line(16'h1232), "good");
    #1 chk("good_hit", 32'(rdata_a), 32'h1232);

    // Reset mid-fill; a late pmem_resp must be ignored.
    address_a = 16'h4000;
    cyc;
    chk("rf_pread", 32'(pmem_read), 32'd1);
    #2 reset = 1'b1;
    #1 chk("rf_pread_drop", 32'(pmem_read), 32'd0);
    chk("rf_paddr", 32'(pmem_address), 32'd0);
    read_a = 1'b0;
    cyc;
    reset = 1'b0;
    pmem_resp = 1'b1; pmem_rdata = mk_line(16'h4000);
    #1 chk("late_resp", 32'(resp_a), 32'd0);
    cyc;
    pmem_resp = 1'b0;
    read_a = 1'b1;
    #1 chk("late_pread", 32'(pmem_read), 32'd0);
    chk("late_nohit", 32'(resp_a), 32'd0);
    cyc;
    chk("late_refill", 32'(pmem_address), 32'h4000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/ifetch_line_buffer.md
IFETCH_LINE_BUFFER -- requirements
Module: ifetch_line_buffer

Interface
REQ-001: clk  input  1  sole clock; all state updates on its rising edge.
REQ-002: reset  input  1  asynchronous, active-high reset.
REQ-003: read_a  input  1  fetch request, level; held by the fetch stage until resp_a is seen.
REQ-004: address_a  input  16 (lc3b_word)  fetch byte address; bit 0 ignored.
REQ-005: flush  input  1  one-cycle pulse that invalidates the buffered line.
REQ-006: resp_a  output  1  fetch complete; rdata_a valid this cycle.
REQ-007: rdata_a  output  16 (lc3b_word)  instruction word at address_a.
REQ-008: pmem_read  output  1  line read request to physical memory, held until pmem_resp.
REQ-009: pmem_address  output  16  line-aligned address, bits [3:0] always 0.
REQ-010: pmem_resp  input  1  one-cycle pulse; pmem_rdata valid this cycle.
REQ-011: pmem_rdata  input  128 (lc3b_line)  eight-word line; word k at bits [16k+15:16k].

Function
REQ-012: State SHALL be one line buffer: valid bit, 12-bit tag (address [15:4]), 128-bit data.
REQ-013: FSM states SHALL be IDLE and FILL only.
REQ-014: Hit = IDLE && read_a && valid && tag==address_a[15:4] && !flush.
REQ-015: On hit, resp_a=1 combinationally in the same cycle; zero wait states.
REQ-016: On hit, rdata_a = buffer word address_a[3:1]; rdata_a=16'h0000 whenever resp_a=0.
REQ-017: IDLE && read_a && !hit -> FILL next cycle; latch fill tag = address_a[15:4].
REQ-018: In FILL, pmem_read=1 and pmem_address={fill tag,4'b0000}; both held stable until pmem_resp.
REQ-019: In FILL, on pmem_resp: write data and tag, valid=1 (unless discard), next state IDLE.
REQ-020: resp_a SHALL be 0 in FILL; the requested word is delivered by the following IDLE hit.
REQ-021: Miss latency = (cycles to pmem_resp) + 1 from request to resp_a.
REQ-022: address_a changing or read_a dropping during FILL SHALL NOT abort the fill; IDLE re-evaluates afterward.
REQ-023: flush in IDLE clears valid; flush coincident with a would-be hit suppresses resp_a and starts a FILL if read_a.
REQ-024: flush during FILL (including the pmem_resp cycle) sets discard; the fill completes but leaves valid=0; discard clears on FILL exit.
REQ-025: pmem_read SHALL be 0 in IDLE; no back-to-back FILL without one IDLE cycle.

Reset
REQ-026: While reset: state IDLE, valid=0, discard=0, resp_a=0, rdata_a=0, pmem_read=0, pmem_address=0.
REQ-027: reset mid-FILL abandons the fill; a pmem_resp arriving after reset releases SHALL be ignored in IDLE.
REQ-028: Buffer data and tag need not be reset.

Structure
REQ-029: lc3b_word and lc3b_line (128-bit) typedefs SHALL live in lc3b_types; no new package constants.
REQ-030: One sub-module: line_word_select (128-bit line + 3-bit offset -> 16-bit word).

Verification
REQ-031: After reset, read_a=1, address_a=16'h3004 -> pmem_read=1 and pmem_address=16'h3000 next cycle. With pmem_resp after 3 cycles and line word2=16'h1234, resp_a=1 and rdata_a=16'h1234 one cycle later.
REQ-032: Sequential fetches at 16'h3000..16'h300E after fill -> resp_a=1 on 8 consecutive cycles, words 0..7 in order, pmem_read=0 throughout.
REQ-033: Fetch 16'h300E then 16'h3010 -> second fetch misses and issues pmem_address=16'h3010.
REQ-034: flush pulsed with a hit at 16'h3002 -> resp_a=0 that cycle, then FILL of 16'h3000.
REQ-035: Mid-FILL of 16'h3000, address_a changes to 16'h4000 -> fill completes, then a miss issues pmem_address=16'h4000. In a repeat where flush is pulsed during the FILL, valid stays 0 and 16'h3000 re-misses.
REQ-036: reset asserted mid-FILL -> pmem_read drops immediately, and a late pmem_resp produces no resp_a.
